// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send,
// then device-clocked 11-bit frame with ACK check and response timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int RTS_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int TW = $clog2(PH_MAX + 1);
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] RTS_LAST = TW'(RTS_CYCLES - 1);
    localparam logic [OW-1:0] TMO_LAST = OW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT
    } state_t;

    state_t state, state_d;

    logic [2:0]    clk_h;
    logic [1:0]    dat_h;
    logic          clk_s, dat_s, fall;
    logic [TW-1:0] tmr;
    logic [OW-1:0] tmo_cnt;
    logic [3:0]    bitcnt;
    logic [2:0]    bidx;
    logic [7:0]    data_lat;
    logic          par, accept, counting, tmo_hit;
    logic          clk_oe_d, data_oe_d, busy_d, done_d;
    logic          clk_oe_q, data_oe_q, busy_q, done_q, ack_err_q;

    // Idle bus is high, so the history starts high to avoid a false fall
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            clk_h <= '1;
            dat_h <= '1;
        end else begin
            clk_h <= {clk_h[1:0], PS2_CLK_IN};
            dat_h <= {dat_h[0], PS2_DATA_IN};
        end
    end

    assign clk_s    = clk_h[1];
    assign dat_s    = dat_h[1];
    assign fall     = clk_h[2] & ~clk_h[1];
    assign par      = ~^data_lat;
    assign bidx     = bitcnt[2:0] - 3'd1;
    assign accept   = (state == S_IDLE) && start && !done_q;
    assign counting = state inside {S_SEND, S_ACK, S_WAIT};
    assign tmo_hit  = counting && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:    if (accept) state_d = S_INHIBIT;
            S_INHIBIT: if (tmr == INH_LAST) state_d = S_RTS;
            S_RTS:     if (tmr == RTS_LAST) state_d = S_SEND;
            S_SEND: begin
                if (tmo_hit) state_d = S_IDLE;
                else if (fall && bitcnt == 4'd9) state_d = S_ACK;
            end
            S_ACK: begin
                if (tmo_hit) state_d = S_IDLE;
                else if (fall) state_d = S_WAIT;
            end
            S_WAIT:    if (tmo_hit || (clk_s && dat_s)) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        clk_oe_d  = state inside {S_INHIBIT, S_RTS};
        data_oe_d = 1'b0;
        if (state == S_RTS) begin
            data_oe_d = 1'b1;
        end else if (state == S_SEND && !tmo_hit) begin
            if (bitcnt == 4'd0)      data_oe_d = 1'b1;
            else if (bitcnt <= 4'd8) data_oe_d = ~data_lat[bidx];
            else if (bitcnt == 4'd9) data_oe_d = ~par;
        end
        done_d = (state != S_IDLE) && (state_d == S_IDLE);
        busy_d = (state != S_IDLE) && !done_d;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Timeout counts only once CLK is actually released on the pad side
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            tmr       <= '0;
            tmo_cnt   <= '0;
            bitcnt    <= '0;
            data_lat  <= '0;
            ack_err_q <= 1'b0;
        end else begin
            if (state_d != state)
                tmr <= '0;
            else if (state inside {S_INHIBIT, S_RTS})
                tmr <= tmr + TW'(1);
            else
                tmr <= '0;

            if (!counting)
                tmo_cnt <= '0;
            else if (!clk_oe_q)
                tmo_cnt <= tmo_cnt + OW'(1);

            if (state inside {S_IDLE, S_INHIBIT, S_RTS})
                bitcnt <= '0;
            else if (state == S_SEND && fall && !tmo_hit)
                bitcnt <= bitcnt + 4'd1;

            if (accept) begin
                data_lat  <= data;
                ack_err_q <= 1'b0;
            end else if (tmo_hit) begin
                ack_err_q <= 1'b1;
            end else if (state == S_ACK && fall) begin
                ack_err_q <= dat_s;
            end
        end
    end

    assign PS2_CLK_OE  = clk_oe_q;
    assign PS2_DATA_OE = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard that
// clocks the frame, captures the wire bits and answers ACK or NACK.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int RTS = 4;
    localparam int TMO = 3000;
    localparam int HP  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       clk_oe, data_oe, busy, done, ack_err;
    logic       ps2_clk, ps2_dat;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [10:0] bits;
    logic [10:0] fexp;

    assign ps2_clk = dev_clk & ~clk_oe;
    assign ps2_dat = dev_dat & ~data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK      (clk),
        .RESET      (rst),
        .start      (start),
        .data       (data),
        .PS2_CLK_IN (ps2_clk),
        .PS2_DATA_IN(ps2_dat),
        .PS2_CLK_OE (clk_oe),
        .PS2_DATA_OE(data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wire order: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2) == 0;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic do_start(input logic [7:0] d);
        @(negedge clk);
        start = 1'b1;
        data  = d;
        @(negedge clk);
        start = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic device(input bit ack, input int nfall, output logic [10:0] got);
        int t;
        got = '0;
        t = 0;
        while (clk_oe !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        check("dev_see_inhibit", clk_oe, 1);
        t = 0;
        while (clk_oe !== 1'b0 && t < INH + RTS + 50) begin @(negedge clk); t++; end
        check("dev_see_release", clk_oe, 0);
        for (int k = 0; k < nfall; k++) begin
            repeat (HP) @(negedge clk);
            got[k] = ps2_dat;
            if (k == 10) begin
                if (ack) dev_dat = 1'b0;
                repeat (3) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (HP) @(negedge clk);
            if (k < nfall - 1 || nfall == 11) dev_clk = 1'b1;
        end
        if (nfall == 11) begin
            repeat (3) @(negedge clk);
            dev_dat = 1'b1;
        end
    endtask

    task automatic wait_done(input bit exp_err, input string tag);
        int t = 0;
        while (done !== 1'b1 && t < TMO + 500) begin @(negedge clk); t++; end
        done_cyc = cyc;
        check({tag, "_done"}, done, 1);
        check({tag, "_ackerr"}, ack_err, exp_err);
        check({tag, "_oe_busy"}, {clk_oe, data_oe, busy}, 0);
        @(negedge clk);
        check({tag, "_done_w"}, done, 0);
        check({tag, "_ackerr_hold"}, ack_err, exp_err);
    endtask

    task automatic run_xfer(input logic [7:0] d, input bit ack, input string tag);
        logic [10:0] got;
        do_start(d);
        fork
            device(ack, 11, got);
            wait_done(!ack, tag);
        join
        check({tag, "_frame"}, got, frame_of(d));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int e, dc, n;
        logic [7:0] rd;
        logic [7:0] rb;
        bit ra;

        repeat (3) @(negedge clk);
        check("rst_clk_oe", clk_oe, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        do_start(8'hED);
        fork
            begin
                check("t_busy_e0", busy, 0);
                @(negedge clk);
                check("t_busy_e1", busy, 1);
                check("t_clk_oe_e1", clk_oe, 1);
                check("t_data_oe_e1", data_oe, 0);
                repeat (INH - 1) @(negedge clk);
                check("t_data_oe_before", data_oe, 0);
                @(negedge clk);
                check("t_data_oe_rts", data_oe, 1);
                repeat (RTS - 1) @(negedge clk);
                check("t_clk_oe_before", clk_oe, 1);
                @(negedge clk);
                check("t_clk_oe_rel", clk_oe, 0);
            end
            device(1'b1, 11, bits);
            wait_done(1'b0, "ed");
        join
        check("ed_frame", bits, frame_of(8'hED));
        check("ed_frame_lit", bits, 11'b11_1110_1101_0);

        run_xfer(8'hF4, 1'b1, "f4");
        run_xfer(8'h00, 1'b1, "z0");
        run_xfer(8'hA5, 1'b0, "nack");
        repeat (5) @(negedge clk);
        check("nack_held", ack_err, 1);

        do_start(8'h12);
        check("tmo_ackerr_clr", ack_err, 0);
        n = 0;
        while (clk_oe !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (clk_oe !== 1'b0 && n < INH + RTS + 50) begin @(negedge clk); n++; end
        e = cyc;
        wait_done(1'b1, "tmo");
        check("tmo_len", done_cyc - e, TMO);

        dc = done_cnt;
        do_start(8'hFF);
        fork
            device(1'b1, 11, bits);
            wait_done(1'b0, "ff");
            begin
                repeat (30) @(negedge clk);
                start = 1'b1; data = 8'h55;
                @(negedge clk);
                start = 1'b0;
                repeat (200) @(negedge clk);
                start = 1'b1; data = 8'h55;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check("ff_frame", bits, frame_of(8'hFF));
        repeat (50) @(negedge clk);
        check("ff_one_done", done_cnt - dc, 1);
        check("ff_idle", busy, 0);

        for (int i = 0; i < 5; i++) begin
            rb = 8'($urandom);
            ra = ($urandom_range(0, 3) != 0);
            run_xfer(rb, ra, "rnd");
        end

        rd = 8'hE3;
        fexp = frame_of(rd);
        do_start(rd);
        device(1'b1, 5, bits);
        repeat (6) @(negedge clk);
        check("mid_frame_bits", bits[4:0], fexp[4:0]);
        check("mid_data_oe", data_oe, !rd[4]);
        check("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_oe", {clk_oe, data_oe}, 0);
        check("arst_busy", busy, 0);
        check("arst_ack_err", ack_err, 0);
        @(negedge clk);
        rst = 1'b0;
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);

        n = 0;
        do_start(8'h5A);
        fork
            begin
                for (int i = 0; i < INH + RTS + 50; i++) begin
                    @(negedge clk);
                    if (data_oe) break;
                    if (clk_oe) n++;
                end
            end
            device(1'b1, 11, bits);
            wait_done(1'b0, "post_rst");
        join
        check("post_rst_inhibit", n, INH);
        check("post_rst_frame", bits, frame_of(8'h5A));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
